pc_ctrl: RTL

Fetch sequencer for the 16-bit program counter. Each cycle it decides whether the PC advances, branches, jumps through a register, holds, or is forced to a fixed address. Forced addresses cover the SIIC exception vector and the RTI return to the saved EPC. It sits between instruction memory, the decoder and the PC register's next-address mux, and owns the EPC register and the halted state.

---
 rtl/pc_ctrl_pkg.sv | 14 +
 rtl/cla16b.sv | 46 ++++
 rtl/pc_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the program-counter fetch sequencer.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXC   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam logic [15:0] EXC_VEC_DEFAULT = 16'h0002;
  localparam logic [15:0] PC_STEP         = 16'h0002;

endpackage

// File: rtl/cla16b.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
module cla16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  cg;

  always_comb begin
    g = a & b;
    p = a ^ b;
    for (int i = 0; i < 4; i++) begin
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
      gp[i] = &p[4*i +: 4];
    end
    // second-level lookahead across the four groups
    cg[0] = cin;
    cg[1] = gg[0] | (gp[0] & cin);
    cg[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    cg[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    cg[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    for (int i = 0; i < 4; i++) begin
      c[4*i] = cg[i];
      for (int j = 1; j < 4; j++) begin
        c[4*i+j] = g[4*i+j-1] | (p[4*i+j-1] & c[4*i+j-1]);
      end
    end
    sum  = p ^ c;
    cout = cg[4];
  end

endmodule

// File: rtl/pc_ctrl.sv
// Fetch sequencer: picks the next-PC source each cycle and owns EPC,
// the exception nesting flag, the sticky nested-exception error and halt.
//
// state | meaning
// FETCH | instruction memory read issued, waiting for a word
// WAIT  | memory stalled; PC held until a clean done
// EXC   | one bubble cycle after SIIC while PC loads the vector
// HALT  | stopped until reset
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [15:0] EXC_VEC = EXC_VEC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_cur,
  input  logic        imem_done,
  input  logic        imem_stall,
  input  logic        br_taken,
  input  logic        reg_jmp,
  input  logic        halt_req,
  input  logic        siic_req,
  input  logic        rti_req,
  output logic        imem_rd,
  output logic        instr_valid,
  output logic        pc_sel,
  output logic        reg_jmp_o,
  output logic        pc_hold,
  output logic        force_addr,
  output logic [15:0] force_val,
  output logic [15:0] epc,
  output logic        halted,
  output logic        err
);

  state_t      state, state_nxt;
  logic [15:0] epc_q, epc_nxt;
  logic        in_exc, in_exc_nxt;
  logic        err_q, err_nxt;
  logic [15:0] pc_plus2;
  logic        cout_unused;

  cla16b u_inc (
    .a    (pc_cur),
    .b    (PC_STEP),
    .cin  (1'b0),
    .sum  (pc_plus2),
    .cout (cout_unused)
  );

  always_comb begin
    state_nxt   = state;
    epc_nxt     = epc_q;
    in_exc_nxt  = in_exc;
    err_nxt     = err_q;
    imem_rd     = 1'b0;
    instr_valid = 1'b0;
    pc_sel      = 1'b0;
    reg_jmp_o   = 1'b0;
    pc_hold     = 1'b0;
    force_addr  = 1'b0;
    force_val   = 16'h0000;
    halted      = 1'b0;

    if (rst) begin
      pc_hold = 1'b1;
    end else begin
      case (state)
        ST_FETCH, ST_WAIT: begin
          imem_rd = 1'b1;
          if (imem_stall) begin
            pc_hold   = 1'b1;
            state_nxt = ST_WAIT;
          end else if (!imem_done) begin
            pc_hold = 1'b1;
          end else begin
            instr_valid = 1'b1;
            state_nxt   = ST_FETCH;
            if (siic_req) begin
              if (!in_exc) begin
                epc_nxt    = pc_plus2;
                in_exc_nxt = 1'b1;
                force_addr = 1'b1;
                force_val  = EXC_VEC;
                state_nxt  = ST_EXC;
              end else begin
                err_nxt   = 1'b1;
                pc_hold   = 1'b1;
                state_nxt = ST_HALT;
              end
            end else if (halt_req) begin
              pc_hold   = 1'b1;
              state_nxt = ST_HALT;
            end else if (rti_req) begin
              force_addr = 1'b1;
              force_val  = epc_q;
              in_exc_nxt = 1'b0;
            end else if (reg_jmp) begin
              reg_jmp_o = 1'b1;
            end else if (br_taken) begin
              pc_sel = 1'b1;
            end
          end
        end
        ST_EXC: begin
          pc_hold   = 1'b1;
          state_nxt = ST_FETCH;
        end
        default: begin
          halted  = 1'b1;
          pc_hold = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_FETCH;
      epc_q  <= 16'h0000;
      in_exc <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      epc_q  <= epc_nxt;
      in_exc <= in_exc_nxt;
      err_q  <= err_nxt;
    end
  end

  // registered values are masked so every output except pc_hold reads 0 in reset
  assign epc = rst ? 16'h0000 : epc_q;
  assign err = err_q & ~rst;

endmodule
